// File: rtl/blake2_pkg.sv
// Shared BLAKE2b constants: word type, scheduler state encoding and the
// RFC 7693 SIGMA message permutation.
package blake2_pkg;

   localparam int WORD_W = 64;
   typedef logic [WORD_W-1:0] word_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // One row per entry; permutation position 0 sits in the most significant nibble.
   localparam logic [63:0] SIGMA [10] = '{
      64'h0123456789abcdef,
      64'hea489fd61c02b753,
      64'hb8c052fdae367194,
      64'h7931dcbe265a40f8,
      64'h905724afe1bc683d,
      64'h2c6a0b834d75fe19,
      64'hc51fed4a0763928b,
      64'hdb7ec13950f4862a,
      64'h6fe9b308c2d714a5,
      64'ha2847615fb9e3cd0
   };

   // Rounds 10..15 reuse the permutation rows from the start of the table.
   function automatic logic [3:0] sigma_row(input logic [3:0] round);
      return (round >= 4'd10) ? (round - 4'd10) : round;
   endfunction

endpackage

// File: rtl/blake2_m_select_if.sv
// Message-pair channel from the scheduler to the round controller.
// Handshake: the producer raises m_valid with a stable pair (m0, m1, round,
// g_idx); a transfer happens on each rising edge where m_valid & m_ready; the
// producer holds the pair and m_valid until that transfer occurs.
interface blake2_m_select_if;
   import blake2_pkg::*;

   logic       m_valid;
   logic       m_ready;
   word_t      m0;
   word_t      m1;
   logic [3:0] round;
   logic [2:0] g_idx;

   modport master (
      output m_valid, m0, m1, round, g_idx,
      input  m_ready
   );

   modport slave (
      input  m_valid, m0, m1, round, g_idx,
      output m_ready
   );

endinterface

// File: rtl/blake2_sigma.sv
// Combinational SIGMA lookup: (row, G index) -> the two message word indices.
module blake2_sigma
   import blake2_pkg::*;
(
   input  logic [3:0] row_i,
   input  logic [2:0] g_i,
   output logic [3:0] idx0_o,
   output logic [3:0] idx1_o
);

   logic [63:0] row_bits;
   logic [7:0]  pair_bits;
   logic [5:0]  pair_lsb;

   // G index g occupies byte (7 - g) counted from the least significant end.
   assign pair_lsb = {~g_i, 3'b000};

   always_comb begin
      row_bits = SIGMA[0];
      for (int r = 0; r < 10; r++) begin
         if (row_i == 4'(r)) begin
            row_bits = SIGMA[r];
         end
      end
      pair_bits = row_bits[pair_lsb +: 8];
      idx0_o    = pair_bits[7:4];
      idx1_o    = pair_bits[3:0];
   end

endmodule

// File: rtl/blake2_m_select.sv
// BLAKE2b message-word scheduler: holds one 16-word block and streams the
// (m0, m1) pairs for every G call of every round over a valid/ready channel.
module blake2_m_select
   import blake2_pkg::*;
#(
   parameter int NUM_ROUNDS = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [3:0]           addr,
   input  word_t                wdata,
   input  logic                 start,
   blake2_m_select_if.master    m_if,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

   word_t      msg_q [16];
   word_t      msg_d [16];
   logic [1:0] state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [2:0] g_q, g_d;
   word_t      m0_q, m0_d;
   word_t      m1_q, m1_d;

   logic [3:0] nxt_round;
   logic [2:0] nxt_g;
   logic [3:0] idx0, idx1;
   logic       last_pair;

   assign last_pair = (round_q == LAST_ROUND) && (g_q == 3'd7);

   // Position of the pair that would be presented next; (0,0) when launching.
   always_comb begin
      nxt_round = 4'd0;
      nxt_g     = 3'd0;
      if (state_q == ST_ISSUE) begin
         nxt_g     = g_q + 3'd1;
         nxt_round = (g_q == 3'd7) ? (round_q + 4'd1) : round_q;
      end
   end

   blake2_sigma u_sigma (
      .row_i  (sigma_row(nxt_round)),
      .g_i    (nxt_g),
      .idx0_o (idx0),
      .idx1_o (idx1)
   );

   // Writes land before the lookup so a same-cycle start sees the new word.
   always_comb begin
      msg_d = msg_q;
      if ((state_q == ST_IDLE) && we) begin
         msg_d[addr] = wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      g_d     = g_q;
      m0_d    = m0_q;
      m1_d    = m1_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               round_d = 4'd0;
               g_d     = 3'd0;
               m0_d    = msg_d[idx0];
               m1_d    = msg_d[idx1];
            end
         end
         ST_ISSUE: begin
            if (m_if.m_ready) begin
               if (last_pair) begin
                  state_d = ST_DONE;
                  round_d = 4'd0;
                  g_d     = 3'd0;
               end else begin
                  round_d = nxt_round;
                  g_d     = nxt_g;
                  m0_d    = msg_d[idx0];
                  m1_d    = msg_d[idx1];
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         round_q <= 4'd0;
         g_q     <= 3'd0;
         m0_q    <= '0;
         m1_q    <= '0;
         for (int i = 0; i < 16; i++) begin
            msg_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         g_q     <= g_d;
         m0_q    <= m0_d;
         m1_q    <= m1_d;
         msg_q   <= msg_d;
      end
   end

   assign m_if.m_valid = (state_q == ST_ISSUE);
   assign m_if.m0      = m0_q;
   assign m_if.m1      = m1_q;
   assign m_if.round   = round_q;
   assign m_if.g_idx   = g_q;
   assign busy         = (state_q == ST_ISSUE);
   assign done         = (state_q == ST_DONE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_blake2_m_select.sv
// Scoreboard bench for blake2_m_select: a 12-round instance under random
// traffic and a 1-round instance for the short-schedule corner.
module tb_blake2_m_select;
   import blake2_pkg::*;

   localparam int NR_A = 12;
   localparam int NR_B = 1;
   localparam int W    = 135;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       we_a, start_a, busy_a, done_a;
   logic [3:0] addr_a;
   word_t      wdata_a;
   logic [1:0] st_a;
   logic       we_b, start_b, busy_b, done_b;
   logic [3:0] addr_b;
   word_t      wdata_b;
   logic [1:0] st_b;

   blake2_m_select_if if_a ();
   blake2_m_select_if if_b ();

   blake2_m_select #(.NUM_ROUNDS(NR_A)) dut_a (
      .clk(clk), .reset(reset), .we(we_a), .addr(addr_a), .wdata(wdata_a),
      .start(start_a), .m_if(if_a), .busy(busy_a), .done(done_a), .dbg_state(st_a)
   );

   blake2_m_select #(.NUM_ROUNDS(NR_B)) dut_b (
      .clk(clk), .reset(reset), .we(we_b), .addr(addr_b), .wdata(wdata_b),
      .start(start_b), .m_if(if_b), .busy(busy_b), .done(done_b), .dbg_state(st_b)
   );

   // ---------------- reference model ----------------
   int sigma_tbl [10][16] = '{
      '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
      '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
      '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
      '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
      '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
      '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
      '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
      '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
      '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
      '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
   };

   word_t mem_a [16];
   word_t mem_b [16];
   logic [W-1:0] exp_a [$];
   logic [W-1:0] exp_b [$];

   int checks = 0;
   int errors = 0;
   int xfer_a = 0, done_cnt_a = 0, xfer_b = 0, done_cnt_b = 0;

   function automatic logic [W-1:0] exp_pair(input word_t mem [16], input int r, input int g);
      int row;
      row = r % 10;
      return {mem[sigma_tbl[row][2*g]], mem[sigma_tbl[row][2*g+1]], 4'(r), 3'(g)};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   logic [W-1:0] cur_a, cur_b, snap_a, snap_b;
   logic stall_a = 1'b0, stall_b = 1'b0, prev_done_a = 1'b0, prev_done_b = 1'b0;
   assign cur_a = {if_a.m0, if_a.m1, if_a.round, if_a.g_idx};
   assign cur_b = {if_b.m0, if_b.m1, if_b.round, if_b.g_idx};

   always @(negedge clk) begin
      if (reset) begin
         stall_a     = 1'b0;
         prev_done_a = 1'b0;
      end else begin
         if (stall_a) begin
            check("a_hold_valid", W'(if_a.m_valid), W'(1));
            check("a_hold_pair", cur_a, snap_a);
         end
         if (if_a.m_valid && if_a.m_ready) begin
            xfer_a++;
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_pair actual=%h expected=none", cur_a);
            end else begin
               check("a_pair", cur_a, exp_a.pop_front());
            end
         end
         if (done_a) begin
            done_cnt_a++;
            check("a_done_width", W'(prev_done_a), W'(0));
            check("a_done_drained", W'(exp_a.size()), W'(0));
         end
         prev_done_a = done_a;
         stall_a     = if_a.m_valid && !if_a.m_ready;
         snap_a      = cur_a;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         stall_b     = 1'b0;
         prev_done_b = 1'b0;
      end else begin
         if (stall_b) begin
            check("b_hold_pair", cur_b, snap_b);
         end
         if (if_b.m_valid && if_b.m_ready) begin
            xfer_b++;
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_pair actual=%h expected=none", cur_b);
            end else begin
               check("b_pair", cur_b, exp_b.pop_front());
            end
         end
         if (done_b) begin
            done_cnt_b++;
            check("b_done_width", W'(prev_done_b), W'(0));
            check("b_done_drained", W'(exp_b.size()), W'(0));
         end
         prev_done_b = done_b;
         stall_b     = if_b.m_valid && !if_b.m_ready;
         snap_b      = cur_b;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_word(input bit sel_b, input logic [3:0] a, input word_t d);
      @(posedge clk); #1;
      if (sel_b) begin we_b = 1'b1; addr_b = a; wdata_b = d; mem_b[a] = d; end
      else       begin we_a = 1'b1; addr_a = a; wdata_a = d; mem_a[a] = d; end
      @(posedge clk); #1;
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   task automatic start_a_sched(input bit with_write, input logic [3:0] a, input word_t d);
      @(posedge clk); #1;
      start_a = 1'b1;
      we_a    = with_write;
      addr_a  = a;
      wdata_a = d;
      if (with_write) mem_a[a] = d;
      for (int r = 0; r < NR_A; r++)
         for (int g = 0; g < 8; g++)
            exp_a.push_back(exp_pair(mem_a, r, g));
      @(posedge clk); #1;
      start_a = 1'b0;
      we_a    = 1'b0;
      check("a_first_valid", W'(if_a.m_valid), W'(1));
      check("a_busy_after_start", W'(busy_a), W'(1));
   endtask

   task automatic run_a(input bit rand_ready, input bit inject_ignored);
      int x0, d0, cyc;
      x0  = xfer_a;
      d0  = done_cnt_a;
      cyc = 0;
      while (done_cnt_a == d0 && cyc < 3000) begin
         @(posedge clk); #1;
         if_a.m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (inject_ignored && cyc == 20) begin
            we_a = 1'b1; addr_a = 4'd0; wdata_a = 64'hDEAD; start_a = 1'b1;
         end else begin
            we_a = 1'b0; start_a = 1'b0;
         end
         cyc++;
      end
      we_a = 1'b0;
      start_a = 1'b0;
      if_a.m_ready = 1'b0;
      if (done_cnt_a == d0) begin
         checks++;
         errors++;
         $display("FAIL a_done_timeout actual=no_done required=done_within_3000");
      end
      check("a_xfer_count", W'(xfer_a - x0), W'(NR_A * 8));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0, found;
      reset = 1'b1;
      we_a = 1'b0; start_a = 1'b0; addr_a = '0; wdata_a = '0;
      we_b = 1'b0; start_b = 1'b0; addr_b = '0; wdata_b = '0;
      if_a.m_ready = 1'b0;
      if_b.m_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_valid", W'(if_a.m_valid), W'(0));
      check("rst_a_busy_done", W'({busy_a, done_a}), W'(0));
      check("rst_a_pair", cur_a, W'(0));
      reset = 1'b0;

      // Block m[i] = i+1; word 0 written in the same cycle as start.
      for (int i = 1; i < 16; i++) write_word(1'b0, 4'(i), word_t'(i + 1));
      start_a_sched(1'b1, 4'd0, 64'd1);
      run_a(1'b0, 1'b0);

      // Same block rerun under random backpressure.
      start_a_sched(1'b0, 4'd0, '0);
      run_a(1'b1, 1'b0);

      // Write and start while busy must be ignored; the rerun shows m[0] kept.
      start_a_sched(1'b0, 4'd0, '0);
      run_a(1'b1, 1'b1);
      start_a_sched(1'b0, 4'd0, '0);
      run_a(1'b0, 1'b0);

      // Random block.
      for (int i = 0; i < 16; i++) write_word(1'b0, 4'(i), {$urandom, $urandom});
      start_a_sched(1'b0, 4'd0, '0);
      run_a(1'b1, 1'b0);

      // Reset while stalled at r5 g3.
      start_a_sched(1'b0, 4'd0, '0);
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(posedge clk); #1;
         if (if_a.m_valid && if_a.round == 4'd5 && if_a.g_idx == 3'd3) begin
            if_a.m_ready = 1'b0;
            found = 1;
         end else begin
            if_a.m_ready = 1'b1;
         end
      end
      if (found == 0) begin
         checks++;
         errors++;
         $display("FAIL a_reach_r5g3 actual=not_reached required=reached");
      end
      @(posedge clk); #2;
      d0 = done_cnt_a;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", W'(if_a.m_valid), W'(0));
      check("mid_rst_busy_done", W'({busy_a, done_a}), W'(0));
      exp_a.delete();
      for (int i = 0; i < 16; i++) mem_a[i] = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_no_done", W'(done_cnt_a), W'(d0));
      start_a_sched(1'b0, 4'd0, '0);
      check("post_rst_first_pair", cur_a, W'(0));
      run_a(1'b0, 1'b0);

      // Single-round instance: 8 transfers then a one-cycle done.
      for (int i = 0; i < 16; i++) write_word(1'b1, 4'(i), {$urandom, $urandom});
      @(posedge clk); #1;
      start_b = 1'b1;
      for (int g = 0; g < 8; g++) exp_b.push_back(exp_pair(mem_b, 0, g));
      @(posedge clk); #1;
      start_b = 1'b0;
      if_b.m_ready = 1'b1;
      d0 = done_cnt_b;
      for (int c = 0; c < 50 && done_cnt_b == d0; c++) @(posedge clk);
      #1;
      if_b.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("b_done_count", W'(done_cnt_b - d0), W'(1));
      check("b_xfer_count", W'(xfer_b), W'(NR_B * 8));
      check("b_idle_after", W'({busy_b, done_b, if_b.m_valid}), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
